// File: rtl/arb_packet_pkg.sv
// Shared types, default widths and grant-decode helpers for arb_packet_mux.
package arb_packet_pkg;

    localparam int unsigned DEF_CLIENTS    = 16;
    localparam int unsigned DEF_DATA_WIDTH = 32;
    // Grant helpers operate on a fixed-width vector; CLIENTS must not exceed it
    localparam int unsigned MAX_CLIENTS    = 64;
    localparam int unsigned MAX_IDX_W      = 6;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // True when exactly one bit of v is set
    function automatic logic is_onehot(input logic [MAX_CLIENTS-1:0] v);
        return (v != '0) && ((v & (v - MAX_CLIENTS'(1))) == '0);
    endfunction

    // Index of the set bit of a one-hot vector (OR-reduction of bit positions)
    function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_CLIENTS-1:0] v);
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < MAX_CLIENTS; i++) begin
            if (v[i]) idx = idx | MAX_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/arb_packet_out_reg.sv
// Single-entry valid/ready output slot carrying {last, id, data}.
module arb_packet_out_reg
    import arb_packet_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned IDW        = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_last,
    input  logic [IDW-1:0]        i_id,
    input  logic                  i_ready,
    output logic                  o_ready_c,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_last,
    output logic [IDW-1:0]        o_id
);

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  last_q, last_d;
    logic [IDW-1:0]        id_q, id_d;

    // Slot can take a beat when empty or when its current beat leaves this cycle
    assign o_ready_c = ~valid_q | i_ready;

    // Load on accept, drain on downstream ready, otherwise hold
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        id_d    = id_q;
        if (i_load) begin
            valid_d = 1'b1;
            data_d  = i_data;
            last_d  = i_last;
            id_d    = i_id;
        end else if (i_ready) begin
            valid_d = 1'b0;
        end
    end

    // Slot registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            id_q    <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
            id_q    <= id_d;
        end
    end

    assign o_valid = valid_q;
    assign o_data  = data_q;
    assign o_last  = last_q;
    assign o_id    = id_q;

endmodule

// File: rtl/arb_packet_mux.sv
// Packet mux behind a round-robin arbiter: locks onto the granted client until
// its last beat is accepted and forwards beats through a registered slot.
// Optional watchdog: define ARB_PACKET_MUX_TIMEOUT_EN to release stalled locks.
module arb_packet_mux
    import arb_packet_pkg::*;
#(
    parameter int unsigned CLIENTS    = DEF_CLIENTS,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned IDW        = (CLIENTS > 1) ? $clog2(CLIENTS) : 1
`ifdef ARB_PACKET_MUX_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT    = 64
`endif
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [CLIENTS-1:0]            i_valid,
    input  logic [CLIENTS*DATA_WIDTH-1:0] i_data,
    input  logic [CLIENTS-1:0]            i_last,
    output logic [CLIENTS-1:0]            o_ready,
    output logic [CLIENTS-1:0]            o_req,
    output logic                          o_block_arb,
    input  logic [CLIENTS-1:0]            i_gnt,
    output logic                          o_valid,
    output logic [DATA_WIDTH-1:0]         o_data,
    output logic                          o_last,
    output logic [IDW-1:0]                o_id,
    input  logic                          i_ready,
    output logic                          o_gnt_err,
    output logic                          o_timeout
);

    state_t                state_q, state_d;
    logic [IDW-1:0]        owner_q, owner_d;
    logic                  gnt_err_q, gnt_err_d;

    logic                  gnt_onehot_c;
    logic                  gnt_multi_c;
    logic [IDW-1:0]        gnt_idx_c;
    logic                  slot_ready_c;
    logic                  accept_c;
    logic                  own_valid_c;
    logic                  own_last_c;
    logic [DATA_WIDTH-1:0] own_data_c;

`ifdef ARB_PACKET_MUX_TIMEOUT_EN
    localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;
`endif

    // Request vector is the raw client valids
    assign o_req = i_valid;

    // Grant decode
    assign gnt_onehot_c = is_onehot(MAX_CLIENTS'(i_gnt));
    assign gnt_multi_c  = (|i_gnt) & ~gnt_onehot_c;
    assign gnt_idx_c    = IDW'(onehot_to_idx(MAX_CLIENTS'(i_gnt)));

    // Owner lane select
    assign own_valid_c = i_valid[owner_q];
    assign own_last_c  = i_last[owner_q];
    assign own_data_c  = i_data[32'(owner_q) * DATA_WIDTH +: DATA_WIDTH];

    // Next-state, lock capture, per-client ready and watchdog
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        gnt_err_d   = 1'b0;
        o_ready     = '0;
        o_block_arb = 1'b0;
        accept_c    = 1'b0;
`ifdef ARB_PACKET_MUX_TIMEOUT_EN
        cnt_d       = '0;
        timeout_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                // Freeze the arbiter as soon as a grant is presented
                o_block_arb = |i_gnt;
                if (gnt_onehot_c && i_valid[gnt_idx_c]) begin
                    owner_d = gnt_idx_c;
                    state_d = LOCKED;
                end else if (gnt_multi_c) begin
                    gnt_err_d = 1'b1;
                end
            end
            LOCKED: begin
                o_block_arb      = 1'b1;
                o_ready[owner_q] = slot_ready_c;
                accept_c         = own_valid_c & slot_ready_c;
                if (accept_c && own_last_c) begin
                    state_d = IDLE;
                end
`ifdef ARB_PACKET_MUX_TIMEOUT_EN
                if (!accept_c) begin
                    if (cnt_q == CW'(TIMEOUT - 1)) begin
                        state_d   = IDLE;
                        timeout_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            gnt_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            gnt_err_q <= gnt_err_d;
        end
    end

`ifdef ARB_PACKET_MUX_TIMEOUT_EN
    // Watchdog registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end
    assign o_timeout = timeout_q;
`else
    assign o_timeout = 1'b0;
`endif

    assign o_gnt_err = gnt_err_q;

    arb_packet_out_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .IDW        (IDW)
    ) u_out_reg (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .i_load    (accept_c),
        .i_data    (own_data_c),
        .i_last    (own_last_c),
        .i_id      (owner_q),
        .i_ready   (i_ready),
        .o_ready_c (slot_ready_c),
        .o_valid   (o_valid),
        .o_data    (o_data),
        .o_last    (o_last),
        .o_id      (o_id)
    );

endmodule

// File: tb/tb_arb_packet_mux.sv
// Directed, table-driven bench for arb_packet_mux (16 clients, 32-bit data).
// Client k's lane carries (k << 8) | dbase so the sourcing client is visible in o_data.
module tb_arb_packet_mux;

    logic          i_clk;
    logic          i_rst_n;
    logic [15:0]   i_valid;
    logic [511:0]  i_data;
    logic [15:0]   i_last;
    logic [15:0]   o_ready;
    logic [15:0]   o_req;
    logic          o_block_arb;
    logic [15:0]   i_gnt;
    logic          o_valid;
    logic [31:0]   o_data;
    logic          o_last;
    logic [3:0]    o_id;
    logic          i_ready;
    logic          o_gnt_err;
    logic          o_timeout;

    int checks;
    int failures;

`ifdef ARB_PACKET_MUX_TIMEOUT_EN
    arb_packet_mux #(.CLIENTS(16), .DATA_WIDTH(32), .TIMEOUT(8)) dut (
`else
    arb_packet_mux #(.CLIENTS(16), .DATA_WIDTH(32)) dut (
`endif
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_valid     (i_valid),
        .i_data      (i_data),
        .i_last      (i_last),
        .o_ready     (o_ready),
        .o_req       (o_req),
        .o_block_arb (o_block_arb),
        .i_gnt       (i_gnt),
        .o_valid     (o_valid),
        .o_data      (o_data),
        .o_last      (o_last),
        .o_id        (o_id),
        .i_ready     (i_ready),
        .o_gnt_err   (o_gnt_err),
        .o_timeout   (o_timeout)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [15:0] valid;
        logic [15:0] last;
        logic [15:0] gnt;
        logic        rdy;
        logic [7:0]  dbase;
        logic [15:0] exp_ready;
        logic        exp_block;
        logic        exp_ov;
        logic [31:0] exp_data;
        logic        exp_last;
        logic [3:0]  exp_id;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [15:0] v, l, g, input logic r, input logic [7:0] d,
                                input logic [15:0] erdy, input logic eblk, input logic eov,
                                input logic [31:0] edat, input logic elast, input logic [3:0] eid,
                                input logic eerr);
        vec_t t;
        t.valid = v; t.last = l; t.gnt = g; t.rdy = r; t.dbase = d;
        t.exp_ready = erdy; t.exp_block = eblk; t.exp_ov = eov;
        t.exp_data = edat; t.exp_last = elast; t.exp_id = eid; t.exp_err = eerr;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs and let combinational outputs settle
    task automatic drive(input logic [15:0] v, l, g, input logic r, input logic [7:0] d);
        i_valid = v;
        i_last  = l;
        i_gnt   = g;
        i_ready = r;
        for (int k = 0; k < 16; k++) i_data[k*32 +: 32] = (32'(k) << 8) | 32'(d);
        #1;
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        // Basic packet: client 3, beats A0..A3
        vecs.push_back(mk(16'h0008, 16'h0000, 16'h0000, 1, 8'h00, 16'h0000, 0, 0, 32'h0,   0, 4'd0, 0));
        vecs.push_back(mk(16'h0008, 16'h0000, 16'h0008, 1, 8'hA0, 16'h0000, 1, 0, 32'h0,   0, 4'd0, 0));
        vecs.push_back(mk(16'h0008, 16'h0000, 16'h0008, 1, 8'hA0, 16'h0008, 1, 1, 32'h3A0, 0, 4'd3, 0));
        vecs.push_back(mk(16'h0008, 16'h0000, 16'h0008, 1, 8'hA1, 16'h0008, 1, 1, 32'h3A1, 0, 4'd3, 0));
        vecs.push_back(mk(16'h0008, 16'h0000, 16'h0008, 1, 8'hA2, 16'h0008, 1, 1, 32'h3A2, 0, 4'd3, 0));
        vecs.push_back(mk(16'h0008, 16'h0008, 16'h0008, 1, 8'hA3, 16'h0008, 1, 1, 32'h3A3, 1, 4'd3, 0));
        vecs.push_back(mk(16'h0000, 16'h0000, 16'h0000, 1, 8'h00, 16'h0000, 0, 0, 32'h0,   0, 4'd0, 0));
        // Backpressure: client 2, three stalled cycles, last beat drains after FSM is idle
        vecs.push_back(mk(16'h0004, 16'h0000, 16'h0004, 1, 8'hB0, 16'h0000, 1, 0, 32'h0,   0, 4'd0, 0));
        vecs.push_back(mk(16'h0004, 16'h0000, 16'h0004, 1, 8'hB0, 16'h0004, 1, 1, 32'h2B0, 0, 4'd2, 0));
        vecs.push_back(mk(16'h0004, 16'h0000, 16'h0004, 0, 8'hB1, 16'h0000, 1, 1, 32'h2B0, 0, 4'd2, 0));
        vecs.push_back(mk(16'h0004, 16'h0000, 16'h0004, 0, 8'hB1, 16'h0000, 1, 1, 32'h2B0, 0, 4'd2, 0));
        vecs.push_back(mk(16'h0004, 16'h0000, 16'h0004, 0, 8'hB1, 16'h0000, 1, 1, 32'h2B0, 0, 4'd2, 0));
        vecs.push_back(mk(16'h0004, 16'h0000, 16'h0004, 1, 8'hB1, 16'h0004, 1, 1, 32'h2B1, 0, 4'd2, 0));
        vecs.push_back(mk(16'h0004, 16'h0004, 16'h0004, 1, 8'hB2, 16'h0004, 1, 1, 32'h2B2, 1, 4'd2, 0));
        vecs.push_back(mk(16'h0000, 16'h0000, 16'h0000, 0, 8'h00, 16'h0000, 0, 1, 32'h2B2, 1, 4'd2, 0));
        vecs.push_back(mk(16'h0000, 16'h0000, 16'h0000, 1, 8'h00, 16'h0000, 0, 0, 32'h0,   0, 4'd0, 0));
        // Contention: clients 1 and 5; stale grant to 1 after its packet is ignored
        vecs.push_back(mk(16'h0022, 16'h0000, 16'h0000, 1, 8'h00, 16'h0000, 0, 0, 32'h0,   0, 4'd0, 0));
        vecs.push_back(mk(16'h0022, 16'h0000, 16'h0002, 1, 8'hC0, 16'h0000, 1, 0, 32'h0,   0, 4'd0, 0));
        vecs.push_back(mk(16'h0022, 16'h0000, 16'h0002, 1, 8'hC0, 16'h0002, 1, 1, 32'h1C0, 0, 4'd1, 0));
        vecs.push_back(mk(16'h0022, 16'h0022, 16'h0002, 1, 8'hC1, 16'h0002, 1, 1, 32'h1C1, 1, 4'd1, 0));
        vecs.push_back(mk(16'h0020, 16'h0020, 16'h0002, 1, 8'h00, 16'h0000, 1, 0, 32'h0,   0, 4'd0, 0));
        vecs.push_back(mk(16'h0020, 16'h0000, 16'h0020, 1, 8'hD0, 16'h0000, 1, 0, 32'h0,   0, 4'd0, 0));
        vecs.push_back(mk(16'h0020, 16'h0000, 16'h0020, 1, 8'hD0, 16'h0020, 1, 1, 32'h5D0, 0, 4'd5, 0));
        vecs.push_back(mk(16'h0020, 16'h0020, 16'h0020, 1, 8'hD1, 16'h0020, 1, 1, 32'h5D1, 1, 4'd5, 0));
        vecs.push_back(mk(16'h0000, 16'h0000, 16'h0000, 1, 8'h00, 16'h0000, 0, 0, 32'h0,   0, 4'd0, 0));
        // Grant errors: multi-hot grant, then one-hot grant to a client without valid
        vecs.push_back(mk(16'h0006, 16'h0000, 16'h0006, 1, 8'h00, 16'h0000, 1, 0, 32'h0,   0, 4'd0, 1));
        vecs.push_back(mk(16'h0000, 16'h0000, 16'h0000, 1, 8'h00, 16'h0000, 0, 0, 32'h0,   0, 4'd0, 0));
        vecs.push_back(mk(16'h0000, 16'h0000, 16'h0010, 1, 8'h00, 16'h0000, 1, 0, 32'h0,   0, 4'd0, 0));
        vecs.push_back(mk(16'h0000, 16'h0000, 16'h0000, 1, 8'h00, 16'h0000, 0, 0, 32'h0,   0, 4'd0, 0));
        // Owner drops valid mid-packet: lock and ready held, nothing emitted
        vecs.push_back(mk(16'h0080, 16'h0000, 16'h0080, 1, 8'hE0, 16'h0000, 1, 0, 32'h0,   0, 4'd0, 0));
        vecs.push_back(mk(16'h0080, 16'h0000, 16'h0000, 1, 8'hE0, 16'h0080, 1, 1, 32'h7E0, 0, 4'd7, 0));
        vecs.push_back(mk(16'h0000, 16'h0000, 16'h0000, 1, 8'h00, 16'h0080, 1, 0, 32'h0,   0, 4'd0, 0));
        vecs.push_back(mk(16'h0000, 16'h0000, 16'h0000, 1, 8'h00, 16'h0080, 1, 0, 32'h0,   0, 4'd0, 0));
        vecs.push_back(mk(16'h0080, 16'h0080, 16'h0000, 1, 8'hE1, 16'h0080, 1, 1, 32'h7E1, 1, 4'd7, 0));
        vecs.push_back(mk(16'h0000, 16'h0000, 16'h0000, 1, 8'h00, 16'h0000, 0, 0, 32'h0,   0, 4'd0, 0));

        // Reset state
        i_rst_n = 1'b0;
        drive(16'h0, 16'h0, 16'h0, 1'b0, 8'h00);
        #10;
        chk("rst_valid", 32'(o_valid), 32'h0);
        chk("rst_data", o_data, 32'h0);
        chk("rst_id", 32'(o_id), 32'h0);
        chk("rst_ready", 32'(o_ready), 32'h0);
        chk("rst_block", 32'(o_block_arb), 32'h0);
        chk("rst_err", 32'(o_gnt_err), 32'h0);
        chk("rst_tmo", 32'(o_timeout), 32'h0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        tick();

        // Vector table
        foreach (vecs[i]) begin
            drive(vecs[i].valid, vecs[i].last, vecs[i].gnt, vecs[i].rdy, vecs[i].dbase);
            chk($sformatf("v%0d_req", i), 32'(o_req), 32'(vecs[i].valid));
            chk($sformatf("v%0d_ready", i), 32'(o_ready), 32'(vecs[i].exp_ready));
            chk($sformatf("v%0d_block", i), 32'(o_block_arb), 32'(vecs[i].exp_block));
            tick();
            chk($sformatf("v%0d_ovalid", i), 32'(o_valid), 32'(vecs[i].exp_ov));
            chk($sformatf("v%0d_gnterr", i), 32'(o_gnt_err), 32'(vecs[i].exp_err));
            chk($sformatf("v%0d_timeout", i), 32'(o_timeout), 32'h0);
            if (vecs[i].exp_ov) begin
                chk($sformatf("v%0d_data", i), o_data, vecs[i].exp_data);
                chk($sformatf("v%0d_last", i), 32'(o_last), 32'(vecs[i].exp_last));
                chk($sformatf("v%0d_id", i), 32'(o_id), 32'(vecs[i].exp_id));
            end
        end

        // Reset mid-packet: client 9 locked with a held beat
        drive(16'h0200, 16'h0, 16'h0200, 1'b0, 8'hF0);
        tick();
        drive(16'h0200, 16'h0, 16'h0000, 1'b0, 8'hF0);
        tick();
        chk("mid_pre_valid", 32'(o_valid), 32'h1);
        chk("mid_pre_data", o_data, 32'h9F0);
        i_rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(o_valid), 32'h0);
        chk("mid_rst_data", o_data, 32'h0);
        chk("mid_rst_id", 32'(o_id), 32'h0);
        chk("mid_rst_ready", 32'(o_ready), 32'h0);
        chk("mid_rst_block", 32'(o_block_arb), 32'h0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        tick();
        drive(16'h0200, 16'h0, 16'h0200, 1'b1, 8'hF1);
        chk("mid_post_idle_ready", 32'(o_ready), 32'h0);
        tick();
        chk("mid_post_idle_valid", 32'(o_valid), 32'h0);
        drive(16'h0200, 16'h0200, 16'h0000, 1'b1, 8'hF1);
        chk("mid_post_lock_ready", 32'(o_ready), 32'h0200);
        tick();
        chk("mid_post_data", o_data, 32'h9F1);
        chk("mid_post_last", 32'(o_last), 32'h1);
        drive(16'h0, 16'h0, 16'h0, 1'b1, 8'h00);
        tick();

`ifdef ARB_PACKET_MUX_TIMEOUT_EN
        // Watchdog: client 6 stalls after one beat, client 10 waits
        drive(16'h0040, 16'h0, 16'h0040, 1'b1, 8'h60);
        tick();
        drive(16'h0440, 16'h0, 16'h0000, 1'b1, 8'h60);
        chk("tmo_first_ready", 32'(o_ready), 32'h0040);
        tick();
        chk("tmo_first_data", o_data, 32'h660);
        for (int s = 0; s < 8; s++) begin
            drive(16'h0400, 16'h0, 16'h0000, 1'b1, 8'h00);
            chk($sformatf("tmo_s%0d_ready", s), 32'(o_ready), 32'h0040);
            chk($sformatf("tmo_s%0d_block", s), 32'(o_block_arb), 32'h1);
            tick();
            chk($sformatf("tmo_s%0d_pulse", s), 32'(o_timeout), (s == 7) ? 32'h1 : 32'h0);
            chk($sformatf("tmo_s%0d_ovalid", s), 32'(o_valid), 32'h0);
        end
        drive(16'h0400, 16'h0, 16'h0400, 1'b1, 8'h70);
        chk("tmo_idle_ready", 32'(o_ready), 32'h0);
        chk("tmo_idle_block", 32'(o_block_arb), 32'h1);
        tick();
        chk("tmo_pulse_end", 32'(o_timeout), 32'h0);
        chk("tmo_no_synth_beat", 32'(o_valid), 32'h0);
        drive(16'h0400, 16'h0400, 16'h0000, 1'b1, 8'h70);
        chk("tmo_next_ready", 32'(o_ready), 32'h0400);
        tick();
        chk("tmo_next_data", o_data, 32'hA70);
        chk("tmo_next_id", 32'(o_id), 32'hA);
        chk("tmo_next_last", 32'(o_last), 32'h1);
        drive(16'h0, 16'h0, 16'h0, 1'b1, 8'h00);
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
